// File: rtl/wr_ptr_full.sv
// wr_ptr_full: write-side async-FIFO pointer, full and sticky-overflow logic; define WR_PTR_LEVEL_EN for WLEVEL/WALMOST_FULL.
// Latency: WPTR/WFULL/WLEVEL register on the WCLK edge that accepts the write; WCLKEN is combinational.
// Backpressure: WINC is ignored while WFULL=1; such an attempt sets WOVF until WOVF_CLR.
module wr_ptr_full #(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                 WCLK,
    input  logic                 WRST_n,
    input  logic                 WINC,
    input  logic [ADDR_SIZE:0]   WQ2_RPTR,
    input  logic                 WOVF_CLR,
    output logic [ADDR_SIZE:0]   WPTR,
    output logic [ADDR_SIZE-1:0] WADDR,
    output logic                 WCLKEN,
    output logic                 WFULL,
    output logic                 WALMOST_FULL,
    output logic [ADDR_SIZE:0]   WLEVEL,
    output logic                 WOVF
);

    // Full when the write pointer has lapped the read pointer by exactly one depth:
    // in gray code that is the top two bits inverted and the rest equal.
    localparam logic [ADDR_SIZE:0] FULL_MASK = {2'b11, {(ADDR_SIZE-1){1'b0}}};

    logic [ADDR_SIZE:0] r_wbin;
    logic [ADDR_SIZE:0] r_wptr;
    logic               r_wfull;
    logic               r_wovf;

    logic               w_winc_ok;
    logic [ADDR_SIZE:0] w_bin_next;
    logic [ADDR_SIZE:0] w_gray_next;
    logic               w_full_next;

    assign w_winc_ok   = WINC & ~r_wfull;
    assign w_bin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_winc_ok};
    assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
    assign w_full_next = (w_gray_next == (WQ2_RPTR ^ FULL_MASK));

    always_ff @(posedge WCLK or negedge WRST_n) begin
        if (!WRST_n) begin
            r_wbin  <= '0;
            r_wptr  <= '0;
            r_wfull <= 1'b0;
            r_wovf  <= 1'b0;
        end else begin
            r_wbin  <= w_bin_next;
            r_wptr  <= w_gray_next;
            r_wfull <= w_full_next;
            r_wovf  <= (WINC & r_wfull) | (r_wovf & ~WOVF_CLR);
        end
    end

    assign WPTR   = r_wptr;
    assign WADDR  = r_wbin[ADDR_SIZE-1:0];
    assign WCLKEN = w_winc_ok;
    assign WFULL  = r_wfull;
    assign WOVF   = r_wovf;

`ifdef WR_PTR_LEVEL_EN
    localparam logic [ADDR_SIZE:0] AFULL_LVL = AFULL_THRESH[ADDR_SIZE:0];

    logic [ADDR_SIZE:0] w_rbin;
    logic [ADDR_SIZE:0] w_level_next;
    logic [ADDR_SIZE:0] r_wlevel;
    logic               r_walmost_full;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i <= ADDR_SIZE; i++) begin
            w_rbin[i] = ^(WQ2_RPTR >> i);
        end
    end

    assign w_level_next = w_bin_next - w_rbin;

    always_ff @(posedge WCLK or negedge WRST_n) begin
        if (!WRST_n) begin
            r_wlevel       <= '0;
            r_walmost_full <= 1'b0;
        end else begin
            r_wlevel       <= w_level_next;
            r_walmost_full <= (w_level_next >= AFULL_LVL);
        end
    end

    assign WLEVEL       = r_wlevel;
    assign WALMOST_FULL = r_walmost_full;
`else
    assign WLEVEL       = '0;
    assign WALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ptr_full.sv
// Bench for wr_ptr_full (ADDR_SIZE=4, AFULL_THRESH=12): count-based scoreboard model,
// expected outputs queued per cycle and compared after each WCLK edge.
module tb_wr_ptr_full;

    logic       WCLK = 1'b0;
    logic       WRST_n;
    logic       WINC;
    logic [4:0] WQ2_RPTR;
    logic       WOVF_CLR;
    logic [4:0] WPTR;
    logic [3:0] WADDR;
    logic       WCLKEN;
    logic       WFULL;
    logic       WALMOST_FULL;
    logic [4:0] WLEVEL;
    logic       WOVF;

    wr_ptr_full #(.ADDR_SIZE(4), .AFULL_THRESH(12)) dut (
        .WCLK(WCLK), .WRST_n(WRST_n), .WINC(WINC), .WQ2_RPTR(WQ2_RPTR),
        .WOVF_CLR(WOVF_CLR), .WPTR(WPTR), .WADDR(WADDR), .WCLKEN(WCLKEN),
        .WFULL(WFULL), .WALMOST_FULL(WALMOST_FULL), .WLEVEL(WLEVEL), .WOVF(WOVF)
    );

    always #5 WCLK = ~WCLK;

    typedef struct packed {
        logic [4:0] wptr;
        logic [3:0] waddr;
        logic       clken;
        logic       full;
        logic       afull;
        logic [4:0] level;
        logic       ovf;
    } obs_t;

    obs_t exp_q[$];
    obs_t o;
    obs_t e;
    int   n_total = 0;
    int   n_bad   = 0;

    // Model: write count and read count (mod 32); occupancy is their difference.
    logic [4:0] m_wb;
    logic [4:0] m_rb;
    logic       m_full;
    logic       m_ovf;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    // One write-clock cycle: drive, predict, sample WCLKEN before the edge and all else after.
    task automatic step(input logic winc, input logic clr, input logic [4:0] rb);
        logic       acc;
        logic [4:0] lvl;
        obs_t       x;
        WINC     = winc;
        WOVF_CLR = clr;
        m_rb     = rb;
        WQ2_RPTR = to_gray(rb);
        acc      = winc && !m_full;
        m_ovf    = (winc && m_full) || (!clr && m_ovf);
        m_wb     = m_wb + {4'd0, acc};
        lvl      = m_wb - m_rb;
        m_full   = (lvl == 5'd16);
        x.wptr   = to_gray(m_wb);
        x.waddr  = m_wb[3:0];
        x.clken  = acc;
        x.full   = m_full;
        x.ovf    = m_ovf;
`ifdef WR_PTR_LEVEL_EN
        x.level  = lvl;
        x.afull  = (lvl >= 5'd12);
`else
        x.level  = 5'd0;
        x.afull  = 1'b0;
`endif
        exp_q.push_back(x);
        #1;
        o.clken = WCLKEN;
        @(posedge WCLK);
        #1;
        o.wptr  = WPTR;
        o.waddr = WADDR;
        o.full  = WFULL;
        o.afull = WALMOST_FULL;
        o.level = WLEVEL;
        o.ovf   = WOVF;
    endtask

    task automatic model_reset();
        m_wb   = '0;
        m_rb   = '0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic test_reset();
        WRST_n   = 1'b0;
        WINC     = 1'b0;
        WOVF_CLR = 1'b0;
        WQ2_RPTR = '0;
        model_reset();
        #2;
        o = '{WPTR, WADDR, WCLKEN, WFULL, WALMOST_FULL, WLEVEL, WOVF};
        n_total++;
        if (o !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_state: got %p want all zero", o);
        end
        @(negedge WCLK);
        WRST_n = 1'b1;
        @(posedge WCLK);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 5'd0);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL fill[%0d]: got %p want %p", i, o, e);
            end
        end
        n_total++;
        if (WPTR !== 5'b11000 || WADDR !== 4'd0 || WFULL !== 1'b1) begin
            n_bad++;
            $display("FAIL fill_final: got wptr=%b waddr=%0d full=%b want 11000 0 1", WPTR, WADDR, WFULL);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 5'd0);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e || o.wptr !== 5'b11000 || o.clken !== 1'b0 || o.ovf !== 1'b1) begin
                n_bad++;
                $display("FAIL overflow[%0d]: got %p want %p", i, o, e);
            end
        end
        step(1'b0, 1'b1, 5'd0);
        e = exp_q.pop_front();
        n_total++;
        if (o !== e || o.ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %p want %p", o, e);
        end
    endtask

    task automatic test_ovf_set_wins();
        step(1'b1, 1'b1, 5'd0);
        e = exp_q.pop_front();
        n_total++;
        if (o !== e || o.ovf !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set_wins: got %p want %p", o, e);
        end
        step(1'b0, 1'b1, 5'd0);
        e = exp_q.pop_front();
        n_total++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL ovf_reclear: got %p want %p", o, e);
        end
    endtask

    task automatic test_drain();
        step(1'b0, 1'b0, 5'd16);
        e = exp_q.pop_front();
        n_total++;
        if (o !== e || o.full !== 1'b0 || o.waddr !== 4'd0) begin
            n_bad++;
            $display("FAIL drain: got %p want %p", o, e);
        end
        step(1'b1, 1'b0, 5'd16);
        e = exp_q.pop_front();
        n_total++;
        if (o !== e || o.clken !== 1'b1 || o.waddr !== 4'd1) begin
            n_bad++;
            $display("FAIL write_after_drain: got %p want %p", o, e);
        end
    endtask

    // Random producer and a reader that advances one entry at most per cycle.
    task automatic test_back_to_back();
        logic [4:0] rb;
        rb = m_rb;
        for (int i = 0; i < 300; i++) begin
            if ((m_wb != rb) && ($urandom_range(0, 99) < (i < 150 ? 30 : 60)))
                rb = rb + 5'd1;
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0, rb);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL random[%0d]: got %p want %p", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        step(1'b0, 1'b1, m_wb);
        e = exp_q.pop_front();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b0, m_rb);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL burst[%0d]: got %p want %p", i, o, e);
            end
        end
        #3;
        WRST_n = 1'b0;
        #1;
        o = '{WPTR, WADDR, 1'b0, WFULL, WALMOST_FULL, WLEVEL, WOVF};
        n_total++;
        if (o !== obs_t'(0)) begin
            n_bad++;
            $display("FAIL reset_mid_burst: got %p want all zero", o);
        end
        WINC     = 1'b0;
        WOVF_CLR = 1'b0;
        WQ2_RPTR = '0;
        model_reset();
        #1;
        WRST_n = 1'b1;
        @(posedge WCLK);
        #1;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 5'd0);
            e = exp_q.pop_front();
            n_total++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL after_reset[%0d]: got %p want %p", i, o, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_ovf_set_wins();
        test_drain();
        test_back_to_back();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wr_ptr_full.md
WR_PTR_FULL -- requirements
Module: wr_ptr_full

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4, meaning FIFO depth is 2**ADDR_SIZE entries.
REQ-002 SHALL have parameter AFULL_THRESH, default 12, meaning the fill level at or above which WALMOST_FULL asserts (range 1..2**ADDR_SIZE).
REQ-003 SHALL have port WCLK  input  1  write-domain clock, the single clock of the block, rising-edge active.
REQ-004 SHALL have port WRST_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port WINC  input  1  write request from producer.
REQ-006 SHALL have port WQ2_RPTR  input  ADDR_SIZE+1  gray read pointer, already two-flop synchronized into WCLK.
REQ-007 SHALL have port WOVF_CLR  input  1  clears sticky overflow flag.
REQ-008 SHALL have port WPTR  output  ADDR_SIZE+1  registered gray write pointer, sent to the read-domain synchronizer.
REQ-009 SHALL have port WADDR  output  ADDR_SIZE  binary write address to the dual-port memory.
REQ-010 SHALL have port WCLKEN  output  1  memory write strobe, combinational WINC & ~WFULL.
REQ-011 SHALL have port WFULL  output  1  registered full flag.
REQ-012 SHALL have port WALMOST_FULL  output  1  registered almost-full flag.
REQ-013 SHALL have port WLEVEL  output  ADDR_SIZE+1  registered fill level, 0..2**ADDR_SIZE.
REQ-014 SHALL have port WOVF  output  1  sticky overflow flag.

Function
REQ-015 SHALL keep an ADDR_SIZE+1 bit binary count WBIN; next = WBIN + (WINC & ~WFULL), modulo 2**(ADDR_SIZE+1).
REQ-016 SHALL drive WADDR = WBIN[ADDR_SIZE-1:0] and register WPTR = (next>>1) ^ next on each WCLK edge; WPTR changes at most one bit per cycle.
REQ-017 SHALL register WFULL = 1 when gray next equals WQ2_RPTR with its two MSBs inverted and remaining bits equal; else 0.
REQ-018 SHALL assert WFULL on the same edge that registers the 2**ADDR_SIZE-th unread write (zero-cycle latency after that write).
REQ-019 SHALL ignore WINC while WFULL=1: WBIN, WPTR, WADDR hold and WCLKEN=0.
REQ-020 SHALL deassert WFULL on the first WCLK edge at which the comparison in REQ-017 fails due to a new WQ2_RPTR value.
REQ-021 SHALL set WOVF on the edge after any cycle with WINC=1 and WFULL=1; WOVF holds until WOVF_CLR=1 or reset; set wins over simultaneous clear.
REQ-022 SHALL handle pointer wrap transparently: WADDR wraps 2**ADDR_SIZE-1 -> 0, WBIN MSB toggles, no flag glitch.

Reset
REQ-023 SHALL, while WRST_n=0, immediately and without WCLK force WBIN=0, WPTR=0, WADDR=0, WFULL=0, WALMOST_FULL=0, WLEVEL=0, WOVF=0.
REQ-024 SHALL resume normal operation on the first WCLK rising edge after WRST_n returns high; reset mid-burst discards all write state.

Configuration
REQ-025 SHALL, when WR_PTR_LEVEL_EN is defined, convert WQ2_RPTR gray->binary (RBIN), register WLEVEL = next WBIN - RBIN modulo 2**(ADDR_SIZE+1), and register WALMOST_FULL = (that value >= AFULL_THRESH).
REQ-026 SHALL, when WR_PTR_LEVEL_EN is undefined, omit the converter and tie WLEVEL=0 and WALMOST_FULL=0; all other behaviour unchanged.

Verification (ADDR_SIZE=4, AFULL_THRESH=12, WR_PTR_LEVEL_EN defined unless stated)
REQ-027 SHALL cover: reset released, WQ2_RPTR=0, 16 consecutive WINC -> after 16th edge WPTR=5'b11000, WADDR=0, WFULL=1, WLEVEL=16, WALMOST_FULL=1 from 12th edge.
REQ-028 SHALL cover: FIFO full, WINC=1 two more cycles -> WPTR stays 5'b11000, WCLKEN=0, WOVF=1 next edge; WOVF_CLR pulse with WINC=0 -> WOVF=0.
REQ-029 SHALL cover: FIFO full, WQ2_RPTR set to 5'b11000 (reader drained 16) -> next edge WFULL=0, WLEVEL=0, WALMOST_FULL=0; next WINC writes WADDR=0.
REQ-030 SHALL cover: 7 writes then WRST_n low mid-cycle -> WPTR, WADDR, WLEVEL go 0 before next WCLK edge; WFULL=0.
REQ-031 SHALL cover: WINC=1 and WFULL=1 with WOVF_CLR=1 same cycle -> WOVF=1.
REQ-032 SHALL cover: WR_PTR_LEVEL_EN undefined, REQ-027 stimulus -> WFULL/WPTR identical, WLEVEL=0 and WALMOST_FULL=0 throughout.
